instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the instruction ROM address,
//   captures the returned word into the IF/ID register and selects the next PC.
//   Next-PC sources: sequential PC+4, J/JAL (decoded in ID), JR (ID), taken branch (EX).
//   Handles stall/flush bubbles and counts instructions that enter IF/ID.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
//   NOP_WORD   32'h0000_0000   bubble word inserted into IF/ID (sll $0,$0,0)
// PORTS
//   clk            in   1   single clock; all state updates on rising edge
//   reset          in   1   asynchronous, active-high; clears all state immediately
//   stall          in   1   load-use hazard: hold PC and IF/ID
//   branch_taken   in   1   EX-stage branch resolved taken
//   branch_target  in   32  EX-stage branch target address
//   jump_en        in   1   ID holds J/JAL (opcode 6'h02/6'h03)
//   jr_en          in   1   ID holds JR (funct 6'h08)
//   jr_target      in   32  forwarded rs value for JR
//   imem_addr      out  32  ROM address; combinational copy of PC
//   imem_instr     in   32  ROM data; valid in the same cycle as imem_addr
//   ifid_instr     out  32  IF/ID instruction
//   ifid_pc_plus4  out  32  IF/ID PC+4 (used for JAL link and branch offset)
//   ifid_valid     out  1   1 = ifid_instr is a real fetched instruction, 0 = bubble
//   fetch_count    out  32  number of valid instructions latched into IF/ID
// BEHAVIOUR
//   Reset: PC=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0.
//   imem_addr = PC, zero added latency; ROM decodes Address[9:2], so PC[1:0] is always 00.
//   All loaded targets have bits [1:0] forced to 00 before PC update.
//   Jump target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}, computed internally.
//   Per-edge priority (first match wins):
//     1 branch_taken : PC<=branch_target; IF/ID<=bubble (NOP_WORD, valid 0, pc_plus4 0).
//                      Overrides stall and jump/jr; the ID-stage instruction is killed.
//     2 stall        : PC and IF/ID hold; fetch_count holds; jump/jr ignored this cycle
//                      and re-evaluated next cycle with forwarded operands.
//     3 jr_en        : PC<=jr_target; IF/ID<=bubble.
//     4 jump_en      : PC<=jump target; IF/ID<=bubble. jr_en and jump_en both 1 is illegal;
//                      jr_en wins.
//     5 default      : PC<=PC+4; IF/ID<={imem_instr, PC+4, valid 1}; fetch_count+=1.
//   No delay slot: the instruction fetched while a redirect is accepted is discarded.
//   PC+4 and fetch_count wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//   Reset asserted mid-operation: outputs take reset values without waiting for clk;
//   first fetch after deassertion is at RESET_PC.
// TESTING
//   Reset then 3 free-run cycles -> imem_addr 0x0,0x4,0x8,0xC; ifid_pc_plus4=0xC; fetch_count=3.
//   ifid_instr={6'h03,26'd8}, ifid_pc_plus4=0xC, jump_en=1 -> next imem_addr=0x20, ifid_valid=0.
//   stall=1 for 2 cycles at PC=0x10 -> imem_addr stays 0x10, IF/ID unchanged, count unchanged.
//   branch_taken=1, branch_target=0x0C with stall=1 and jump_en=1 -> PC=0x0C, ifid_valid=0.
//   jr_en=1, jr_target=0x13 -> PC=0x10; PC forced to 0xFFFF_FFFC then free-run -> wraps to 0x0.
//   reset pulse between edges at PC=0x40 -> imem_addr=0x0 and fetch_count=0 before next edge.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, drives the ROM address,
// fills the IF/ID register and selects the next PC from sequential/jump/jr/branch.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_HOLD,
        SEL_JR,
        SEL_JUMP
    } pc_sel_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [31:0] count_q;
    pc_sel_t     sel;

    assign imem_addr     = pc;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus4 = pc_plus4_q;
    assign ifid_valid    = valid_q;
    assign fetch_count   = count_q;

    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};

    // Priority: branch (EX) beats stall beats jr beats jump beats sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (branch_taken)
            sel = SEL_BRANCH;
        else if (stall)
            sel = SEL_HOLD;
        else if (jr_en)
            sel = SEL_JR;
        else if (jump_en)
            sel = SEL_JUMP;
    end

    always_comb begin
        redirect_target = '0;
        case (sel)
            SEL_BRANCH: redirect_target = branch_target & WORD_MASK;
            SEL_JR:     redirect_target = jr_target & WORD_MASK;
            SEL_JUMP:   redirect_target = jump_target;
            default:    redirect_target = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC & WORD_MASK;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            case (sel)
                SEL_SEQ: begin
                    pc         <= pc_plus4;
                    instr_q    <= imem_instr;
                    pc_plus4_q <= pc_plus4;
                    valid_q    <= 1'b1;
                    count_q    <= count_q + 32'd1;
                end
                // Any redirect discards the word fetched this cycle (no delay slot).
                SEL_BRANCH, SEL_JR, SEL_JUMP: begin
                    pc         <= redirect_target;
                    instr_q    <= NOP_WORD;
                    pc_plus4_q <= '0;
                    valid_q    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
